// File: rtl/data_memory_port_pkg.sv
// rtl/data_memory_port_pkg.sv - memory-op types, port FSM states and store lane helpers
package data_memory_port_pkg;

  localparam int DMEM_XLEN       = 32;
  localparam int DMEM_BUS_ADDR_W = DMEM_XLEN - 2;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    mem_width_t             width;
    logic                   r_sign_extend;
    logic                   w_enable;
    logic [DMEM_XLEN-1:0]   w_value;
  } compute_mem_control_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ,
    DMEM_WAIT_RSP,
    DMEM_DONE
  } dmem_state_t;

  function automatic logic [3:0] dmem_wstrb(input mem_width_t width, input logic [1:0] off);
    case (width)
      MEM_BYTE: return 4'b0001 << off;
      MEM_HALF: return 4'b0011 << {off[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [DMEM_XLEN-1:0] dmem_wdata(input mem_width_t width,
                                                      input logic [DMEM_XLEN-1:0] val);
    case (width)
      MEM_BYTE: return {4{val[7:0]}};
      MEM_HALF: return {2{val[15:0]}};
      default:  return val;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_port_if.sv
// rtl/data_memory_port_if.sv - execute-side request and word-bus signals of the data memory port
interface data_memory_port_if;
  import data_memory_port_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic [DMEM_XLEN-1:0]         req_addr;
  compute_mem_control_t         req_ctrl;
  logic                         done;
  logic [DMEM_XLEN-1:0]         load_data;
  logic                         fault;
  logic                         bus_req_valid;
  logic                         bus_req_ready;
  logic [DMEM_BUS_ADDR_W-1:0]   bus_addr;
  logic                         bus_we;
  logic [3:0]                   bus_wstrb;
  logic [DMEM_XLEN-1:0]         bus_wdata;
  logic                         bus_rsp_valid;
  logic [DMEM_XLEN-1:0]         bus_rdata;

  modport master (
    input  req_valid, req_addr, req_ctrl, bus_req_ready, bus_rsp_valid, bus_rdata,
    output req_ready, done, load_data, fault, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
  );

  modport slave (
    output req_valid, req_addr, req_ctrl, bus_req_ready, bus_rsp_valid, bus_rdata,
    input  req_ready, done, load_data, fault, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
  );

endinterface

// File: rtl/data_memory_port_load_align_extend.sv
// rtl/data_memory_port_load_align_extend.sv - picks the addressed byte/half of a read word and extends it
module load_align_extend
  import data_memory_port_pkg::*;
(
  input  logic [DMEM_XLEN-1:0] rdata,
  input  logic [1:0]           off,
  input  mem_width_t           width,
  input  logic                 sign,
  output logic [DMEM_XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    result = rdata;
    case (width)
      MEM_BYTE: result = {{24{sign & byte_v[7]}}, byte_v};
      MEM_HALF: result = {{16{sign & half_v[15]}}, half_v};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - load/store request to word bus with byte strobes; MEM_MISALIGN_TRAP_EN enables misalignment faults
module data_memory_port
  import data_memory_port_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BUS_ADDR_W = XLEN - 2
) (
  input  logic clk,
  input  logic rst_n,
  data_memory_port_if.master port
);

  dmem_state_t             state;
  mem_width_t              width_q;
  logic                    sign_q;
  logic [1:0]              off_q;
  logic                    fault_q;
  logic                    misalign;
  logic [1:0]              req_off;
  logic [BUS_ADDR_W-1:0]   word_addr;
  logic [XLEN-1:0]         ext_data;
  compute_mem_control_t    ctrl;

  assign ctrl      = port.req_ctrl;
  assign word_addr = port.req_addr[XLEN-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (ctrl.width == MEM_BYTE) ? 1'b0 :
                    (ctrl.width == MEM_HALF) ? port.req_addr[0] :
                    (port.req_addr[1:0] != 2'b00);
  assign req_off  = port.req_addr[1:0];
`else
  assign misalign = 1'b0;
  // Misaligned halves/words are silently snapped down to their natural boundary.
  always_comb begin
    req_off = 2'b00;
    case (ctrl.width)
      MEM_BYTE: req_off = port.req_addr[1:0];
      MEM_HALF: req_off = {port.req_addr[1], 1'b0};
      default:  req_off = 2'b00;
    endcase
  end
`endif

  assign port.fault = fault_q;

  load_align_extend u_extract (
    .rdata  (port.bus_rdata),
    .off    (off_q),
    .width  (width_q),
    .sign   (sign_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= DMEM_IDLE;
      port.req_ready     <= 1'b1;
      port.done          <= 1'b0;
      port.load_data     <= '0;
      port.bus_req_valid <= 1'b0;
      port.bus_addr      <= '0;
      port.bus_we        <= 1'b0;
      port.bus_wstrb     <= 4'b0000;
      port.bus_wdata     <= '0;
      fault_q            <= 1'b0;
      width_q            <= MEM_WORD;
      sign_q             <= 1'b0;
      off_q              <= 2'b00;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (port.req_valid && port.req_ready) begin
            port.req_ready <= 1'b0;
            width_q        <= ctrl.width;
            sign_q         <= ctrl.r_sign_extend;
            off_q          <= req_off;
            if (misalign) begin
              state          <= DMEM_DONE;
              port.done      <= 1'b1;
              fault_q        <= 1'b1;
              port.load_data <= '0;
            end else begin
              state              <= DMEM_REQ;
              port.bus_req_valid <= 1'b1;
              port.bus_addr      <= word_addr;
              port.bus_we        <= ctrl.w_enable;
              port.bus_wstrb     <= ctrl.w_enable ? dmem_wstrb(ctrl.width, req_off) : 4'b0000;
              port.bus_wdata     <= ctrl.w_enable ? dmem_wdata(ctrl.width, ctrl.w_value) : '0;
            end
          end
        end
        DMEM_REQ: begin
          if (port.bus_req_ready) begin
            port.bus_req_valid <= 1'b0;
            port.bus_we        <= 1'b0;
            port.bus_wstrb     <= 4'b0000;
            if (port.bus_we) begin
              state          <= DMEM_DONE;
              port.done      <= 1'b1;
              port.load_data <= '0;
            end else begin
              state <= DMEM_WAIT_RSP;
            end
          end
        end
        DMEM_WAIT_RSP: begin
          if (port.bus_rsp_valid) begin
            state          <= DMEM_DONE;
            port.done      <= 1'b1;
            port.load_data <= ext_data;
          end
        end
        DMEM_DONE: begin
          state          <= DMEM_IDLE;
          port.done      <= 1'b0;
          port.req_ready <= 1'b1;
          fault_q        <= 1'b0;
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_port.sv
// tb/tb_data_memory_port.sv - vector table, corner sequences and randomized ops against a reference model
module tb_data_memory_port;
  import data_memory_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_port_if bus ();

  data_memory_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  w;
    logic        sign;
    logic        we;
    logic [31:0] wval;
    logic [31:0] rdata;
    int          hold;
    logic [29:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    logic        e_fault;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Expected results from byte-count arithmetic rather than lane tables.
  function automatic void model(input logic [31:0] addr, input logic [1:0] w, input logic sign,
                                input logic we, input logic [31:0] wval, input logic [31:0] rdata,
                                input int hold, output logic [29:0] e_addr, output logic [3:0] e_strb,
                                output logic [31:0] e_wdata, output logic [31:0] e_load,
                                output logic e_fault, output int e_lat);
    int unsigned off, nbytes;
    longint v;
    nbytes  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    off     = addr % 4;
    e_fault = 1'b0;
    if (off % nbytes != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
      e_fault = 1'b1;
`endif
      off = off - off % nbytes;
    end
    e_addr  = 30'(addr >> 2);
    e_strb  = 4'b0;
    e_wdata = 32'b0;
    e_load  = 32'b0;
    if (e_fault) begin
      e_lat = 1;
      return;
    end
    if (we) begin
      e_strb  = 4'(((1 << nbytes) - 1) << off);
      e_wdata = (nbytes == 1) ? 32'(wval[7:0]) * 32'h0101_0101 :
                (nbytes == 2) ? 32'(wval[15:0]) * 32'h0001_0001 : wval;
      e_lat   = 2 + hold;
    end else begin
      v = longint'((64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1));
      if (sign && v >= longint'(64'd1 << (8 * nbytes - 1)))
        v = v - longint'(64'd1 << (8 * nbytes));
      e_load = 32'(v);
      e_lat  = 3 + hold;
    end
  endfunction

  task automatic do_op(input string tag, input vec_t t);
    int c, done_c, waited, req_cycles, hs;
    logic hs_pending, unstable, we0, got_fault;
    logic [29:0] a0;
    logic [3:0] s0;
    logic [31:0] d0, got_load;
    c = 1; done_c = -1; waited = 0; req_cycles = 0; hs = 0;
    hs_pending = 0; unstable = 0; we0 = 0; got_fault = 0;
    a0 = '0; s0 = '0; d0 = '0; got_load = '0;
    check($sformatf("%s accept_ready", tag), 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = t.addr;
    bus.req_ctrl  = {t.w, t.sign, t.we, t.wval};
    @(posedge clk); #1;
    while (c <= 40 && done_c < 0) begin
      bus.bus_rsp_valid = 1'b0;
      bus.bus_req_ready = 1'b0;
      if (hs_pending) begin
        hs++;
        hs_pending = 0;
        if (bus.bus_req_valid) unstable = 1;
        if (!t.we) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rdata     = t.rdata;
        end
      end
      if (bus.done) begin
        done_c    = c;
        got_load  = bus.load_data;
        got_fault = bus.fault;
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rdata     = $urandom();
      end else begin
        if (bus.req_ready) unstable = 1;
        if (bus.bus_req_valid) begin
          if (req_cycles == 0) begin
            a0 = bus.bus_addr; s0 = bus.bus_wstrb; d0 = bus.bus_wdata; we0 = bus.bus_we;
          end else if (a0 !== bus.bus_addr || s0 !== bus.bus_wstrb || d0 !== bus.bus_wdata || we0 !== bus.bus_we)
            unstable = 1;
          req_cycles++;
          if (waited >= t.hold) begin
            bus.bus_req_ready = 1'b1;
            hs_pending = 1;
          end else begin
            waited++;
            bus.bus_rsp_valid = 1'($urandom_range(1));
            bus.bus_rdata     = $urandom();
          end
        end
      end
      // Upstream keeps offering junk while busy; none of it may be taken.
      bus.req_valid = (done_c < 0) ? 1'($urandom_range(1)) : 1'b0;
      bus.req_addr  = $urandom();
      @(posedge clk); #1;
      c++;
    end
    bus.bus_rsp_valid = 1'b0;
    bus.req_valid = 1'b0;
    check($sformatf("%s done_latency", tag), 32'(done_c), 32'(t.e_lat));
    check($sformatf("%s done_pulse", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s ready_after", tag), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s fault", tag), 32'(got_fault), 32'(t.e_fault));
    check($sformatf("%s busy_stable", tag), 32'(unstable), 32'd0);
    if (t.e_fault) begin
      check($sformatf("%s no_bus_req", tag), 32'(req_cycles), 32'd0);
      check($sformatf("%s load_zero", tag), got_load, 32'd0);
    end else begin
      check($sformatf("%s handshakes", tag), 32'(hs), 32'd1);
      check($sformatf("%s bus_addr", tag), 32'(a0), 32'(t.e_addr));
      check($sformatf("%s bus_we", tag), 32'(we0), 32'(t.we));
      check($sformatf("%s bus_wstrb", tag), 32'(s0), 32'(t.e_strb));
      if (t.we) check($sformatf("%s bus_wdata", tag), d0, t.e_wdata);
      else      check($sformatf("%s load_data", tag), got_load, t.e_load);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s done", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s fault", tag), 32'(bus.fault), 32'd0);
    check($sformatf("%s load_data", tag), bus.load_data, 32'd0);
    check($sformatf("%s bus_req_valid", tag), 32'(bus.bus_req_valid), 32'd0);
    check($sformatf("%s bus_we", tag), 32'(bus.bus_we), 32'd0);
    check($sformatf("%s bus_wstrb", tag), 32'(bus.bus_wstrb), 32'd0);
  endtask

  initial begin
    vec_t r;
    int seen_done;
    vecs[0] = '{32'h1003, 2'd0, 1'b0, 1'b1, 32'h0000_00A5, 32'h0, 0, 30'h400, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 2};
    vecs[1] = '{32'h2001, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0000_8000, 0, 30'h800, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 3};
    vecs[2] = '{32'h2001, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_8000, 0, 30'h800, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 3};
    vecs[3] = '{32'h2002, 2'd1, 1'b1, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 3};
    vecs[4] = '{32'h2000, 2'd2, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'h8001_1234, 1'b0, 3};
    vecs[5] = '{32'h1002, 2'd1, 1'b0, 1'b1, 32'h1234_BEEF, 32'h0, 1, 30'h400, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 3};
    vecs[6] = '{32'h1004, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5, 30'h401, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 7};
    vecs[7] = '{32'h2004, 2'd3, 1'b1, 1'b0, 32'h0, 32'h89AB_CDEF, 0, 30'h801, 4'b0000, 32'h0, 32'h89AB_CDEF, 1'b0, 3};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[8] = '{32'h2002, 2'd2, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    vecs[9] = '{32'h2003, 2'd1, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
`else
    vecs[8] = '{32'h2002, 2'd2, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'h8001_1234, 1'b0, 3};
    vecs[9] = '{32'h2003, 2'd1, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b0000, 32'h0, 32'h0000_8001, 1'b0, 3};
`endif

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_ctrl = '0;
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Reset while a load waits for its response; the late response must be dropped.
    bus.req_valid = 1'b1; bus.req_addr = 32'h2000; bus.req_ctrl = {2'd2, 1'b0, 1'b0, 32'h0};
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.load_data != 32'h0) seen_done++;
    end
    bus.bus_rsp_valid = 1'b0;
    check("rst_wait late_rsp_ignored", 32'(seen_done), 32'd0);

    // Reset while a store is presented on the bus drops bus_req_valid without a clock.
    bus.req_valid = 1'b1; bus.req_addr = 32'h1000; bus.req_ctrl = {2'd2, 1'b0, 1'b1, 32'h1111_2222};
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_req bus_req_valid_before", 32'(bus.bus_req_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_req bus_req_valid_async", 32'(bus.bus_req_valid), 32'd0);
    check("rst_req req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      r.addr  = {18'($urandom()), 12'($urandom()), 2'($urandom())};
      r.w     = 2'($urandom_range(3));
      r.sign  = 1'($urandom_range(1));
      r.we    = 1'($urandom_range(1));
      r.wval  = $urandom();
      r.rdata = $urandom();
      r.hold  = $urandom_range(2);
      model(r.addr, r.w, r.sign, r.we, r.wval, r.rdata, r.hold,
            r.e_addr, r.e_strb, r.e_wdata, r.e_load, r.e_fault, r.e_lat);
      do_op($sformatf("rnd%0d", n), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
